// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter bus bundle: both requester ports plus the RAM side.
// slave = arbiter, master = requesters and RAM model.
interface data_mem_arbiter_if #(
    parameter int SIZE       = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  REQ0;
    logic                  REQ1;
    logic                  WE0;
    logic                  WE1;
    logic [ADDR_WIDTH-1:0] ADDR0;
    logic [ADDR_WIDTH-1:0] ADDR1;
    logic [SIZE-1:0]       WDATA0;
    logic [SIZE-1:0]       WDATA1;
    logic                  LOCK0;
    logic                  LOCK1;
    logic                  GNT0;
    logic                  GNT1;
    logic                  RVALID0;
    logic                  RVALID1;
    logic [SIZE-1:0]       RDATA0;
    logic [SIZE-1:0]       RDATA1;
    logic [ADDR_WIDTH-1:0] RAM_ADDR;
    logic [SIZE-1:0]       RAM_WDATA;
    logic                  RAM_WE;
    logic [SIZE-1:0]       RAM_Q;

    modport slave (
        input  REQ0, REQ1, WE0, WE1,
        input  ADDR0, ADDR1, WDATA0, WDATA1,
        input  LOCK0, LOCK1, RAM_Q,
        output GNT0, GNT1, RVALID0, RVALID1,
        output RDATA0, RDATA1,
        output RAM_ADDR, RAM_WDATA, RAM_WE
    );

    modport master (
        output REQ0, REQ1, WE0, WE1,
        output ADDR0, ADDR1, WDATA0, WDATA1,
        output LOCK0, LOCK1, RAM_Q,
        input  GNT0, GNT1, RVALID0, RVALID1,
        input  RDATA0, RDATA1,
        input  RAM_ADDR, RAM_WDATA, RAM_WE
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter for the single-port data RAM.
// Define MEM_ARB_LOCK_EN to build the ownership lock FSM.
module data_mem_arbiter #(
    parameter int SIZE       = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_LOCK   = 16
) (
    input  logic               CLK,
    input  logic               RESET_N,
    data_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    logic                  r_last_grant;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [SIZE-1:0]       r_ram_wdata;
    logic                  r_rd_pend;
    logic                  r_rd_id;
    logic [SIZE-1:0]       r_rdata0;
    logic [SIZE-1:0]       r_rdata1;

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_own0;
    logic                  w_own1;
    logic                  w_force0;
    logic                  w_force1;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [SIZE-1:0]       w_ram_wdata;
    logic                  w_ram_we;
    logic                  w_rvalid0;
    logic                  w_rvalid1;

`ifdef MEM_ARB_LOCK_EN
    localparam int            CW   = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_LOCK);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t        r_state;
    logic [CW-1:0] r_hold;
    logic [CW-1:0] w_hold_inc;
    logic          w_rel0;
    logic          w_rel1;

    assign w_own0     = (r_state == OWN0);
    assign w_own1     = (r_state == OWN1);
    assign w_hold_inc = (r_hold == MAXC) ? r_hold : r_hold + ONE;
    assign w_rel0     = w_gnt0 && !bus.LOCK0;
    assign w_rel1     = w_gnt1 && !bus.LOCK1;
    assign w_force0   = w_own0 && !w_rel0 && (w_hold_inc == MAXC);
    assign w_force1   = w_own1 && !w_rel1 && (w_hold_inc == MAXC);

    // Lock FSM: a locked transfer claims the RAM until release or timeout.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
            r_hold  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_gnt0 && bus.LOCK0) begin
                        r_state <= OWN0;
                        r_hold  <= ONE;
                    end else if (w_gnt1 && bus.LOCK1) begin
                        r_state <= OWN1;
                        r_hold  <= ONE;
                    end
                end
                OWN0: begin
                    if (w_rel0 || w_force0) begin
                        r_state <= IDLE;
                        r_hold  <= '0;
                    end else begin
                        r_hold  <= w_hold_inc;
                    end
                end
                OWN1: begin
                    if (w_rel1 || w_force1) begin
                        r_state <= IDLE;
                        r_hold  <= '0;
                    end else begin
                        r_hold  <= w_hold_inc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_hold  <= '0;
                end
            endcase
        end
    end
`else
    logic w_unused;

    assign w_own0   = 1'b0;
    assign w_own1   = 1'b0;
    assign w_force0 = 1'b0;
    assign w_force1 = 1'b0;
    assign w_unused = &{1'b0, bus.LOCK0, bus.LOCK1, MAX_LOCK[0]};
`endif

    // Grant decode: owner first, then round-robin on conflict.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        priority case (1'b1)
            !RESET_N: begin
            end
            w_own0: begin
                w_gnt0 = bus.REQ0;
            end
            w_own1: begin
                w_gnt1 = bus.REQ1;
            end
            (bus.REQ0 && bus.REQ1): begin
                w_gnt0 = r_last_grant;
                w_gnt1 = !r_last_grant;
            end
            default: begin
                w_gnt0 = bus.REQ0;
                w_gnt1 = bus.REQ1;
            end
        endcase
    end

    // RAM mux: follow the winner, otherwise hold address and data.
    always_comb begin
        w_ram_addr  = r_ram_addr;
        w_ram_wdata = r_ram_wdata;
        w_ram_we    = 1'b0;
        priority case (1'b1)
            w_gnt0: begin
                w_ram_addr  = bus.ADDR0;
                w_ram_wdata = bus.WDATA0;
                w_ram_we    = bus.WE0;
            end
            w_gnt1: begin
                w_ram_addr  = bus.ADDR1;
                w_ram_wdata = bus.WDATA1;
                w_ram_we    = bus.WE1;
            end
            default: begin
            end
        endcase
    end

    // Round-robin pointer; a timed-out owner counts as last granted.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_last_grant <= 1'b1;
        end else if (w_force0) begin
            r_last_grant <= 1'b0;
        end else if (w_force1) begin
            r_last_grant <= 1'b1;
        end else if (w_gnt0) begin
            r_last_grant <= 1'b0;
        end else if (w_gnt1) begin
            r_last_grant <= 1'b1;
        end
    end

    // Remember the last driven address/data for idle cycles.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            r_ram_addr  <= w_ram_addr;
            r_ram_wdata <= w_ram_wdata;
        end
    end

    // Track the owner of the read in flight for response steering.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rd_pend <= 1'b0;
            r_rd_id   <= 1'b0;
        end else begin
            r_rd_pend <= (w_gnt0 && !bus.WE0) || (w_gnt1 && !bus.WE1);
            r_rd_id   <= w_gnt1;
        end
    end

    assign w_rvalid0 = r_rd_pend && !r_rd_id;
    assign w_rvalid1 = r_rd_pend && r_rd_id;

    // Capture delivered read data so RDATA holds between responses.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_rvalid0) begin
                r_rdata0 <= bus.RAM_Q;
            end
            if (w_rvalid1) begin
                r_rdata1 <= bus.RAM_Q;
            end
        end
    end

    assign bus.GNT0      = w_gnt0;
    assign bus.GNT1      = w_gnt1;
    assign bus.RAM_ADDR  = w_ram_addr;
    assign bus.RAM_WDATA = w_ram_wdata;
    assign bus.RAM_WE    = w_ram_we;
    assign bus.RVALID0   = w_rvalid0;
    assign bus.RVALID1   = w_rvalid1;
    assign bus.RDATA0    = w_rvalid0 ? bus.RAM_Q : r_rdata0;
    assign bus.RDATA1    = w_rvalid1 ? bus.RAM_Q : r_rdata1;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a read-response scoreboard.
// Lock expectations follow MEM_ARB_LOCK_EN (MAX_LOCK=4).
module tb_data_mem_arbiter;
    localparam int SIZE = 32;
    localparam int AW   = 10;

    typedef struct {
        logic            id;
        logic [SIZE-1:0] data;
    } resp_t;

    logic CLK;
    logic RESET_N;
    int   errors;
    int   checks;
    resp_t sb[$];
    logic [SIZE-1:0] mem [0:(1<<AW)-1];
    logic [4:0] run1;
    logic [2:0] run2;

    data_mem_arbiter_if #(.SIZE(SIZE), .ADDR_WIDTH(AW)) bus ();

    data_mem_arbiter #(
        .SIZE(SIZE),
        .ADDR_WIDTH(AW),
        .MAX_LOCK(4)
    ) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .bus(bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous read-first RAM model
    always @(posedge CLK) begin
        if (bus.RAM_WE) mem[bus.RAM_ADDR] <= bus.RAM_WDATA;
        bus.RAM_Q <= mem[bus.RAM_ADDR];
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(
        input logic r0, input logic w0, input logic [AW-1:0] a0,
        input logic [SIZE-1:0] d0, input logic l0,
        input logic r1, input logic w1, input logic [AW-1:0] a1,
        input logic [SIZE-1:0] d1, input logic l1);
        bus.REQ0 = r0; bus.WE0 = w0; bus.ADDR0 = a0;
        bus.WDATA0 = d0; bus.LOCK0 = l0;
        bus.REQ1 = r1; bus.WE1 = w1; bus.ADDR1 = a1;
        bus.WDATA1 = d1; bus.LOCK1 = l1;
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, 0, 0, 0, '0, '0, 0);
    endtask

    task automatic push(input logic id, input logic [SIZE-1:0] d);
        resp_t e;
        e.id = id;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic gchk(input string tag, input logic g0, input logic g1,
                        input logic we, input logic [AW-1:0] a,
                        input logic [SIZE-1:0] d);
        #1;
        chk({tag, ".gnt0"}, bus.GNT0, g0);
        chk({tag, ".gnt1"}, bus.GNT1, g1);
        chk({tag, ".we"}, bus.RAM_WE, we);
        chk({tag, ".addr"}, bus.RAM_ADDR, a);
        chk({tag, ".wdata"}, bus.RAM_WDATA, d);
    endtask

    // Advance to the next falling edge and score read responses
    task automatic tick();
        resp_t e;
        @(negedge CLK);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("resp.rv0", bus.RVALID0, !e.id);
            chk("resp.rv1", bus.RVALID1, e.id);
            chk("resp.rdata", e.id ? bus.RDATA1 : bus.RDATA0, e.data);
        end else begin
            chk("quiet.rv0", bus.RVALID0, 1'b0);
            chk("quiet.rv1", bus.RVALID1, 1'b0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
`ifdef MEM_ARB_LOCK_EN
        run1 = 5'b01111;
        run2 = 3'b011;
`else
        run1 = 5'b10101;
        run2 = 3'b010;
`endif
        idle();
        RESET_N = 1'b1;
        #1 RESET_N = 1'b0;
        #11;
        chk("rst.gnt0", bus.GNT0, 1'b0);
        chk("rst.gnt1", bus.GNT1, 1'b0);
        chk("rst.rv0", bus.RVALID0, 1'b0);
        chk("rst.rv1", bus.RVALID1, 1'b0);
        chk("rst.rd0", bus.RDATA0, '0);
        chk("rst.rd1", bus.RDATA1, '0);
        chk("rst.addr", bus.RAM_ADDR, '0);
        chk("rst.wdata", bus.RAM_WDATA, '0);
        chk("rst.we", bus.RAM_WE, 1'b0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // preload through requester 1
        tick();
        drive(0, 0, '0, '0, 0, 1, 1, 10'd5, 32'hDEADBEEF, 0);
        gchk("pre5", 0, 1, 1, 10'd5, 32'hDEADBEEF);
        tick();
        drive(0, 0, '0, '0, 0, 1, 1, 10'd3, 32'hA5A50003, 0);
        gchk("pre3", 0, 1, 1, 10'd3, 32'hA5A50003);
        tick();
        drive(0, 0, '0, '0, 0, 1, 1, 10'd4, 32'h5A5A0004, 0);
        gchk("pre4", 0, 1, 1, 10'd4, 32'h5A5A0004);

        // lone read from requester 0
        tick();
        drive(1, 0, 10'd5, '0, 0, 0, 0, '0, '0, 0);
        gchk("rd5", 1, 0, 0, 10'd5, '0);
        push(1'b0, 32'hDEADBEEF);
        tick();
        idle();
        gchk("hold5", 0, 0, 0, 10'd5, '0);
        tick();
        chk("rd0.hold", bus.RDATA0, 32'hDEADBEEF);

        // reset lands between read grant and response
        drive(1, 0, 10'd3, '0, 0, 0, 0, '0, '0, 0);
        gchk("rdrst", 1, 0, 0, 10'd3, '0);
        #1 RESET_N = 1'b0;
        #1;
        chk("mid.gnt0", bus.GNT0, 1'b0);
        chk("mid.addr", bus.RAM_ADDR, '0);
        chk("mid.we", bus.RAM_WE, 1'b0);
        chk("mid.rv0", bus.RVALID0, 1'b0);
        chk("mid.rd0", bus.RDATA0, '0);
        idle();
        @(posedge CLK);
        #2 RESET_N = 1'b1;
        tick();
        tick();

        // contended writes: requester 0 wins the first conflict
        drive(1, 1, 10'd1, 32'h11, 0, 1, 1, 10'd2, 32'h22, 0);
        gchk("cw0", 1, 0, 1, 10'd1, 32'h11);
        tick();
        gchk("cw1", 0, 1, 1, 10'd2, 32'h22);
        tick();
        gchk("cw2", 1, 0, 1, 10'd1, 32'h11);
        tick();
        gchk("cw3", 0, 1, 1, 10'd2, 32'h22);

        // alternating reads, back to back
        tick();
        drive(0, 0, '0, '0, 0, 1, 0, 10'd3, '0, 0);
        gchk("ar1", 0, 1, 0, 10'd3, '0);
        push(1'b1, 32'hA5A50003);
        tick();
        drive(1, 0, 10'd4, '0, 0, 0, 0, '0, '0, 0);
        gchk("ar0", 1, 0, 0, 10'd4, '0);
        push(1'b0, 32'h5A5A0004);
        tick();
        idle();
        gchk("arh", 0, 0, 0, 10'd4, '0);

        // read back the contended writes
        tick();
        drive(1, 0, 10'd1, '0, 0, 1, 0, 10'd2, '0, 0);
        gchk("rb1", 0, 1, 0, 10'd2, '0);
        push(1'b1, 32'h22);
        tick();
        drive(1, 0, 10'd1, '0, 0, 0, 0, '0, '0, 0);
        gchk("rb0", 1, 0, 0, 10'd1, '0);
        push(1'b0, 32'h11);
        tick();
        idle();
        gchk("rbh", 0, 0, 0, 10'd1, '0);

        // lock held by requester 1 against requester 0
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0)
                drive(1, 1, 10'd10, 32'hA0, 0, 1, 1, 10'd11, 32'hB1, 1);
            gchk("lk1", !run1[i], run1[i], 1,
                 run1[i] ? 10'd11 : 10'd10,
                 run1[i] ? 32'hB1 : 32'hA0);
        end

        // lock dropped on the second transfer
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0)
                drive(1, 1, 10'd10, 32'hA0, 0, 1, 1, 10'd11, 32'hB1, 1);
            if (i == 1)
                drive(1, 1, 10'd10, 32'hA0, 0, 1, 1, 10'd11, 32'hB1, 0);
            gchk("lk2", !run2[i], run2[i], 1,
                 run2[i] ? 10'd11 : 10'd10,
                 run2[i] ? 32'hB1 : 32'hA0);
        end

        tick();
        idle();
        gchk("end", 0, 0, 0, 10'd10, 32'hA0);
        tick();
        tick();
        chk("sb.empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
